// File: rtl/encoder_decoder_pkg.sv
// Shared definitions for the one-hot encode/decode round-trip checker.
package encdec_pkg;

  // Default one-hot vector width.
  localparam int N_DEFAULT = 4;

  // Widest vector the helper functions accept. Narrower vectors are
  // zero-extended before the helpers are called.
  localparam int N_MAX = 32;

  // Returns the index of the highest set bit. An all-zero vector gives 0.
  function automatic int onehot_to_index(input logic [N_MAX-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < N_MAX; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  // True when more than one bit is set. Clearing the lowest set bit
  // leaves something behind only if a second bit was set.
  function automatic logic popcount_gt1(input logic [N_MAX-1:0] vec);
    return (vec & (vec - N_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/encoder_decoder_priority_encoder.sv
// Combinational priority encoder: the highest set bit wins. It also reports
// whether any bit is set and whether more than one bit is set.
module priority_encoder
  import encdec_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_code,
  output logic         o_any,
  output logic         o_multi
);

  // The helpers work on N_MAX-bit vectors, so N must not exceed N_MAX.
  logic [N_MAX-1:0] w_vec_ext;

  assign w_vec_ext = N_MAX'(i_vec);
  assign o_code    = W'(onehot_to_index(w_vec_ext));
  assign o_any     = |i_vec;
  assign o_multi   = popcount_gt1(w_vec_ext);

endmodule

// File: rtl/encoder_decoder.sv
// Two-stage registered round trip.
// Stage 1 priority-encodes original_in into a binary index and flags.
// Stage 2 decodes that index back to one-hot.
// There is no handshake: one input is taken on every rising edge, nothing
// stalls, and every output is a register, so no path runs combinationally
// from input to output.
module encoder_decoder
  import encdec_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] original_in,
  output logic [N-1:0] final_out,
  output logic [W-1:0] code_out,
  output logic         valid_out,
  output logic         multi_hot
);

  logic [W-1:0] w_code;
  logic         w_any;
  logic         w_multi;

  logic [W-1:0] r_code;
  logic         r_s1_valid;
  logic         r_s1_multi;
  logic [N-1:0] r_final;
  logic         r_valid;
  logic         r_multi;

  priority_encoder #(
    .N (N),
    .W (W)
  ) u_priority_encoder (
    .i_vec   (original_in),
    .o_code  (w_code),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  // Stage 1: register the encoded index and its qualifying flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_multi <= 1'b0;
    end else begin
      r_code     <= w_code;
      r_s1_valid <= w_any;
      r_s1_multi <= w_multi;
    end
  end

  // Stage 2: decode the index back to one-hot and carry the flags forward.
  // An empty stage-1 result decodes to zero instead of bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_final <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_final <= r_s1_valid ? (N'(1) << r_code) : '0;
      r_valid <= r_s1_valid;
      r_multi <= r_s1_multi;
    end
  end

  assign code_out  = r_code;
  assign final_out = r_final;
  assign valid_out = r_valid;
  assign multi_hot = r_multi;

endmodule

// File: tb/tb_encoder_decoder.sv
// Bench for encoder_decoder. The reference model keeps the last two inputs
// that the DUT sampled outside reset. It derives the expected outputs with
// plain arithmetic: the highest set index is clog2(v+1)-1, and the multi flag
// comes from counting ones.
module tb_encoder_decoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] original_in;
  logic [N-1:0] final_out;
  logic [W-1:0] code_out;
  logic         valid_out;
  logic         multi_hot;

  int errors = 0;
  int checks = 0;

  // exp_q[0] holds the input sampled two edges ago; exp_q[1] holds the
  // input sampled one edge ago.
  logic [N-1:0] exp_q[$];

  encoder_decoder #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .original_in (original_in),
    .final_out   (final_out),
    .code_out    (code_out),
    .valid_out   (valid_out),
    .multi_hot   (multi_hot)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: record every input sampled while out of reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      exp_q.push_back(original_in);
      if (exp_q.size() > 2) void'(exp_q.pop_front());
    end
  end

  // Reset discards everything in flight, which looks like two zero inputs.
  always @(negedge rst_n) begin
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  end

  function automatic int hi_index(input logic [N-1:0] v);
    int val;
    val = int'(v);
    return (val == 0) ? 0 : $clog2(val + 1) - 1;
  endfunction

  function automatic logic [W-1:0] exp_code();
    return W'(hi_index(exp_q[1]));
  endfunction

  function automatic logic [N-1:0] exp_final();
    logic [N-1:0] one;
    one = 1;
    return (exp_q[0] == 0) ? '0 : (one << hi_index(exp_q[0]));
  endfunction

  function automatic logic exp_valid();
    return exp_q[0] != 0;
  endfunction

  function automatic logic exp_multi();
    return $countones(exp_q[0]) > 1;
  endfunction

  // Driver: apply one input at the falling edge, then move to just after
  // the next rising edge, where the outputs are stable.
  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    original_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    original_in = 4'b1111;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (final_out !== 4'b0000) begin
        errors++;
        $display("FAIL reset_final cycle %0d: got %b want 0000", c, final_out);
      end
      checks++;
      if (code_out !== 2'd0) begin
        errors++;
        $display("FAIL reset_code cycle %0d: got %0d want 0", c, code_out);
      end
      checks++;
      if (valid_out !== 1'b0 || multi_hot !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags cycle %0d: got valid=%b multi=%b want 0/0",
                 c, valid_out, multi_hot);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_onehot_sweep();
    logic [N-1:0] pat [4];
    pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      drive((i < 4) ? pat[i] : 4'b0000);
      if (i >= 0 && i < 4) begin
        checks++;
        if (code_out !== W'(i)) begin
          errors++;
          $display("FAIL sweep_code step %0d: got %0d want %0d", i, code_out, i);
        end
      end
      if (i >= 1 && i < 5) begin
        checks++;
        if (final_out !== pat[i-1] || valid_out !== 1'b1 || multi_hot !== 1'b0) begin
          errors++;
          $display("FAIL sweep_final step %0d: got %b v=%b m=%b want %b v=1 m=0",
                   i, final_out, valid_out, multi_hot, pat[i-1]);
        end
      end
    end
  endtask

  task automatic test_zero_input();
    drive(4'b0000);
    drive(4'b0000);
    checks++;
    if (final_out !== 4'b0000 || valid_out !== 1'b0 || multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL zero_input: got %b v=%b m=%b want 0000 v=0 m=0",
               final_out, valid_out, multi_hot);
    end
  endtask

  task automatic test_multi_hot();
    drive(4'b0110);
    checks++;
    if (code_out !== 2'd2) begin
      errors++;
      $display("FAIL multi_0110_code: got %0d want 2", code_out);
    end
    drive(4'b1001);
    checks++;
    if (final_out !== 4'b0100 || valid_out !== 1'b1 || multi_hot !== 1'b1) begin
      errors++;
      $display("FAIL multi_0110_final: got %b v=%b m=%b want 0100 v=1 m=1",
               final_out, valid_out, multi_hot);
    end
    checks++;
    if (code_out !== 2'd3) begin
      errors++;
      $display("FAIL multi_1001_code: got %0d want 3", code_out);
    end
    drive(4'b0000);
    checks++;
    if (final_out !== 4'b1000 || valid_out !== 1'b1 || multi_hot !== 1'b1) begin
      errors++;
      $display("FAIL multi_1001_final: got %b v=%b m=%b want 1000 v=1 m=1",
               final_out, valid_out, multi_hot);
    end
  endtask

  task automatic test_mid_reset();
    drive(4'b0001);
    drive(4'b0010);
    // Pulse reset between edges and expect the outputs to clear right away.
    #2;
    original_in = 4'b0100;
    rst_n = 1'b0;
    #1;
    checks++;
    if (final_out !== '0 || code_out !== '0 || valid_out !== 1'b0 || multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got f=%b c=%0d v=%b m=%b want all 0",
               final_out, code_out, valid_out, multi_hot);
    end
    #5;
    rst_n = 1'b1;
    // Outputs may show only what was sampled after the release, never a
    // value from before the reset.
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? 4'b1000 : 4'b0000);
      checks++;
      if (final_out !== exp_final() || code_out !== exp_code() ||
          valid_out !== exp_valid() || multi_hot !== exp_multi()) begin
        errors++;
        $display("FAIL mid_reset_after step %0d: got f=%b c=%0d v=%b m=%b want f=%b c=%0d v=%b m=%b",
                 i, final_out, code_out, valid_out, multi_hot,
                 exp_final(), exp_code(), exp_valid(), exp_multi());
      end
      if (i == 1) begin
        checks++;
        if (final_out !== 4'b1000) begin
          errors++;
          $display("FAIL mid_reset_1000: got %b want 1000", final_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100);
      if (i >= 2) begin
        checks++;
        if (final_out !== 4'b0100 || valid_out !== 1'b1) begin
          errors++;
          $display("FAIL hold_0100 edge %0d: got %b v=%b want 0100 v=1",
                   i + 1, final_out, valid_out);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      drive(N'($urandom_range(0, 15)));
      checks++;
      if (final_out !== exp_final() || code_out !== exp_code() ||
          valid_out !== exp_valid() || multi_hot !== exp_multi()) begin
        errors++;
        $display("FAIL random step %0d: got f=%b c=%0d v=%b m=%b want f=%b c=%0d v=%b m=%b",
                 i, final_out, code_out, valid_out, multi_hot,
                 exp_final(), exp_code(), exp_valid(), exp_multi());
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    original_in = '0;
    test_reset();
    test_onehot_sweep();
    test_zero_input();
    test_multi_hot();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
